// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one memory request channel between an instruction fetch port (if_*)
// and a data port (dm_*). At most one transaction is outstanding at a time.
// The request is forwarded combinationally from IDLE. The block waits in WAIT
// for the response, then routes ram_data_ok/ram_rdata back to the owning port.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   flush             cancels instruction-port traffic (masks if_req in IDLE,
//                     drops the response of an in-flight instruction read)
//   if_req/if_addr    instruction read request
//   if_addr_ok/if_data_ok/if_rdata   instruction accept / response / data
//   dm_req/dm_we/dm_addr/dm_wdata/dm_wstrb   data-port request
//   dm_addr_ok/dm_data_ok/dm_rdata   data-port accept / response / data
//   ram_req/ram_we/ram_addr/ram_wdata/ram_wstrb   shared memory request
//   ram_addr_ok/ram_data_ok/ram_rdata   shared memory accept / response / data
//   busy              high while a transaction is outstanding
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  when defined, simultaneous requests go to the port not
//                       granted most recently; otherwise the data port always
//                       wins.
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_addr_ok,
  output logic                  if_data_ok,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  dm_req,
  input  logic                  dm_we,
  input  logic [ADDR_WIDTH-1:0] dm_addr,
  input  logic [DATA_WIDTH-1:0] dm_wdata,
  input  logic [3:0]            dm_wstrb,
  output logic                  dm_addr_ok,
  output logic                  dm_data_ok,
  output logic [DATA_WIDTH-1:0] dm_rdata,
  output logic                  ram_req,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [3:0]            ram_wstrb,
  input  logic                  ram_addr_ok,
  input  logic                  ram_data_ok,
  input  logic [DATA_WIDTH-1:0] ram_rdata,
  output logic                  busy
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic PORT_IF = 1'b0;
  localparam logic PORT_DM = 1'b1;

  logic [0:0] state_r;
  logic       owner_r;
  logic       drop_r;
`ifdef ARB_ROUND_ROBIN_EN
  logic       last_grant_r;
`endif

  logic if_valid_s;
  logic dm_valid_s;
  logic grant_dm_s;
  logic any_req_s;
  logic accept_s;

  // Request qualification and winner selection.
  always_comb begin
    if_valid_s = if_req & ~flush;
    dm_valid_s = dm_req;
`ifdef ARB_ROUND_ROBIN_EN
    // Data port wins only if instruction port is idle or was granted last.
    grant_dm_s = dm_valid_s & (~if_valid_s | (last_grant_r == PORT_IF));
`else
    grant_dm_s = dm_valid_s;
`endif
    any_req_s  = if_valid_s | dm_valid_s;
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    ram_req    = 1'b0;
    ram_we     = 1'b0;
    ram_addr   = {ADDR_WIDTH{1'b0}};
    ram_wdata  = {DATA_WIDTH{1'b0}};
    ram_wstrb  = 4'h0;
    if_addr_ok = 1'b0;
    if_data_ok = 1'b0;
    if_rdata   = {DATA_WIDTH{1'b0}};
    dm_addr_ok = 1'b0;
    dm_data_ok = 1'b0;
    dm_rdata   = {DATA_WIDTH{1'b0}};
    busy       = 1'b0;
    accept_s   = 1'b0;
    if (rst_n == 1'b0) begin
      busy = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (any_req_s) begin
            ram_req = 1'b1;
            if (grant_dm_s) begin
              ram_we    = dm_we;
              ram_addr  = dm_addr;
              ram_wdata = dm_wdata;
              ram_wstrb = dm_wstrb;
            end else begin
              ram_addr  = if_addr;
            end
            accept_s   = ram_addr_ok;
            if_addr_ok = ram_addr_ok & ~grant_dm_s;
            dm_addr_ok = ram_addr_ok & grant_dm_s;
          end else begin
            ram_req = 1'b0;
          end
        end
        ST_WAIT: begin
          busy = 1'b1;
          if (ram_data_ok) begin
            if (owner_r == PORT_DM) begin
              dm_data_ok = 1'b1;
              dm_rdata   = ram_rdata;
            end else if (~drop_r & ~flush) begin
              // Flush in the completion cycle also cancels the fetch.
              if_data_ok = 1'b1;
              if_rdata   = ram_rdata;
            end else begin
              if_data_ok = 1'b0;
            end
          end else begin
            busy = 1'b1;
          end
        end
        default: begin
          busy = 1'b0;
        end
      endcase
    end
  end

  // State, owner, drop flag and last-grant tracking.
  always_ff @(posedge clk) begin
    if (rst_n == 1'b0) begin
      state_r      <= ST_IDLE;
      owner_r      <= PORT_IF;
      drop_r       <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant_r <= PORT_IF;
`endif
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            state_r      <= ST_WAIT;
            owner_r      <= grant_dm_s ? PORT_DM : PORT_IF;
            drop_r       <= ~grant_dm_s & flush;
`ifdef ARB_ROUND_ROBIN_EN
            last_grant_r <= grant_dm_s ? PORT_DM : PORT_IF;
`endif
          end
        end
        ST_WAIT: begin
          if (ram_data_ok) begin
            state_r <= ST_IDLE;
            drop_r  <= 1'b0;
          end else if (flush && (owner_r == PORT_IF)) begin
            drop_r  <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          drop_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Directed scenarios followed by randomized traffic. A transaction-level model
// (pending flag, owner, dropped flag, last granted port) predicts every output
// each cycle. Inputs change 1 ns after the rising edge. Outputs are checked on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_addr_ok, if_data_ok;
  logic [DW-1:0] if_rdata;
  logic          dm_req, dm_we;
  logic [AW-1:0] dm_addr;
  logic [DW-1:0] dm_wdata;
  logic [3:0]    dm_wstrb;
  logic          dm_addr_ok, dm_data_ok;
  logic [DW-1:0] dm_rdata;
  logic          ram_req, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [3:0]    ram_wstrb;
  logic          ram_addr_ok, ram_data_ok;
  logic [DW-1:0] ram_rdata;
  logic          busy;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .if_req(if_req), .if_addr(if_addr),
    .if_addr_ok(if_addr_ok), .if_data_ok(if_data_ok), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb),
    .dm_addr_ok(dm_addr_ok), .dm_data_ok(dm_data_ok), .dm_rdata(dm_rdata),
    .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_wstrb(ram_wstrb),
    .ram_addr_ok(ram_addr_ok), .ram_data_ok(ram_data_ok),
    .ram_rdata(ram_rdata), .busy(busy)
  );

  int vectors = 0;
  int miscompares = 0;

  // Transaction-level model state.
  bit m_pending;
  bit m_owner_dm;
  bit m_dropped;
  bit m_last_dm;

  // Predicted outputs for the current cycle.
  bit            w_dm;
  logic          e_ram_req, e_ram_we;
  logic [AW-1:0] e_ram_addr;
  logic [DW-1:0] e_ram_wdata;
  logic [3:0]    e_ram_wstrb;
  logic          e_if_addr_ok, e_if_data_ok, e_dm_addr_ok, e_dm_data_ok, e_busy;
  logic [DW-1:0] e_if_rdata, e_dm_rdata;

  // Snapshots of DUT outputs taken at the check point.
  logic          s_if_addr_ok, s_if_data_ok, s_dm_addr_ok, s_dm_data_ok, s_busy;
  logic          s_ram_we, s_ram_req;
  logic [AW-1:0] s_ram_addr;
  logic [DW-1:0] s_if_rdata, s_dm_rdata;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic predict();
    bit if_c, dm_c;
    e_ram_req = 1'b0; e_ram_we = 1'b0; e_ram_addr = '0; e_ram_wdata = '0;
    e_ram_wstrb = 4'h0; e_if_addr_ok = 1'b0; e_if_data_ok = 1'b0;
    e_dm_addr_ok = 1'b0; e_dm_data_ok = 1'b0; e_busy = 1'b0;
    e_if_rdata = '0; e_dm_rdata = '0; w_dm = 1'b0;
    if (rst_n !== 1'b1) return;
    if (!m_pending) begin
      if_c = if_req && !flush;
      dm_c = dm_req;
`ifdef ARB_ROUND_ROBIN_EN
      w_dm = dm_c && (!if_c || !m_last_dm);
`else
      w_dm = dm_c;
`endif
      if (if_c || dm_c) begin
        e_ram_req = 1'b1;
        if (w_dm) begin
          e_ram_we = dm_we; e_ram_addr = dm_addr;
          e_ram_wdata = dm_wdata; e_ram_wstrb = dm_wstrb;
          e_dm_addr_ok = ram_addr_ok;
        end else begin
          e_ram_addr = if_addr;
          e_if_addr_ok = ram_addr_ok;
        end
      end
    end else begin
      e_busy = 1'b1;
      if (ram_data_ok) begin
        if (m_owner_dm) begin
          e_dm_data_ok = 1'b1; e_dm_rdata = ram_rdata;
        end else if (!(m_dropped || flush)) begin
          e_if_data_ok = 1'b1; e_if_rdata = ram_rdata;
        end
      end
    end
  endtask

  task automatic advance_model();
    if (rst_n !== 1'b1) begin
      m_pending = 0; m_owner_dm = 0; m_dropped = 0; m_last_dm = 0;
    end else if (!m_pending) begin
      if (e_ram_req && ram_addr_ok) begin
        m_pending = 1; m_owner_dm = w_dm; m_dropped = !w_dm && flush; m_last_dm = w_dm;
      end
    end else if (ram_data_ok) begin
      m_pending = 0; m_dropped = 0;
    end else if (flush && !m_owner_dm) begin
      m_dropped = 1;
    end
  endtask

  // One clock cycle: check at the falling edge, then advance past the rising edge.
  task automatic tick();
    #4;
    predict();
    check("ram_bus", {ram_req, ram_we, ram_addr, ram_wdata, ram_wstrb},
          {e_ram_req, e_ram_we, e_ram_addr, e_ram_wdata, e_ram_wstrb});
    check("if_port", {if_addr_ok, if_data_ok, if_rdata}, {e_if_addr_ok, e_if_data_ok, e_if_rdata});
    check("dm_port", {dm_addr_ok, dm_data_ok, dm_rdata}, {e_dm_addr_ok, e_dm_data_ok, e_dm_rdata});
    check("busy", busy, e_busy);
    s_if_addr_ok = if_addr_ok; s_if_data_ok = if_data_ok; s_if_rdata = if_rdata;
    s_dm_addr_ok = dm_addr_ok; s_dm_data_ok = dm_data_ok; s_dm_rdata = dm_rdata;
    s_busy = busy; s_ram_we = ram_we; s_ram_addr = ram_addr; s_ram_req = ram_req;
    @(posedge clk);
    advance_model();
    #1;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; if_req = 1'b0; if_addr = '0;
    dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_wstrb = 4'h0;
    ram_addr_ok = 1'b0; ram_data_ok = 1'b0; ram_rdata = '0;
    m_pending = 0; m_owner_dm = 0; m_dropped = 0; m_last_dm = 0;
    tick();
    tick();
    check("reset_busy", s_busy, 1'b0);
    rst_n = 1'b1;

    // Single instruction read: accept at cycle 0, respond at cycle 3.
    if_req = 1'b1; if_addr = 32'h0000_0100; ram_addr_ok = 1'b1;
    tick();
    check("r31_addr_ok", s_if_addr_ok, 1'b1);
    check("r31_addr", s_ram_addr, 32'h0000_0100);
    if_req = 1'b0; ram_addr_ok = 1'b0;
    tick();
    check("r31_busy_c1", s_busy, 1'b1);
    tick();
    check("r31_busy_c2", s_busy, 1'b1);
    ram_data_ok = 1'b1; ram_rdata = 32'hDEAD_BEEF;
    tick();
    check("r31_data_ok", s_if_data_ok, 1'b1);
    check("r31_rdata", s_if_rdata, 32'hDEAD_BEEF);
    check("r31_busy_c3", s_busy, 1'b1);
    ram_data_ok = 1'b0; ram_rdata = '0;
    tick();
    check("r31_idle_c4", s_busy, 1'b0);

    // Simultaneous requests, last grant was the instruction port: data port first.
    if_req = 1'b1; if_addr = 32'h0000_0104;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0200; dm_wdata = 32'h1234_5678;
    dm_wstrb = 4'hF; ram_addr_ok = 1'b1;
    tick();
    check("r32_dm_first", {s_dm_addr_ok, s_if_addr_ok}, 2'b10);
    check("r32_ram_we", s_ram_we, 1'b1);
    check("r32_ram_addr", s_ram_addr, 32'h0000_0200);
    dm_req = 1'b0; dm_we = 1'b0; ram_addr_ok = 1'b0;
    tick();
    ram_data_ok = 1'b1;
    tick();
    check("r32_dm_data_ok", s_dm_data_ok, 1'b1);
    ram_data_ok = 1'b0; ram_addr_ok = 1'b1;
    tick();
    check("r32_if_next", s_if_addr_ok, 1'b1);
    if_req = 1'b0; ram_addr_ok = 1'b0; ram_data_ok = 1'b1;
    tick();
    ram_data_ok = 1'b0;

    // Data-only transaction so the last grant is the data port, then collide.
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h0000_0300; ram_addr_ok = 1'b1;
    tick();
    dm_req = 1'b0; ram_addr_ok = 1'b0; ram_data_ok = 1'b1;
    tick();
    ram_data_ok = 1'b0;
    if_req = 1'b1; if_addr = 32'h0000_0108;
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h0000_0204; ram_addr_ok = 1'b1;
    tick();
`ifdef ARB_ROUND_ROBIN_EN
    check("r33_if_first", {s_if_addr_ok, s_dm_addr_ok}, 2'b10);
`else
    check("r33_dm_first", {s_if_addr_ok, s_dm_addr_ok}, 2'b01);
`endif
    if_req = 1'b0; dm_req = 1'b0; dm_we = 1'b0; ram_addr_ok = 1'b0; ram_data_ok = 1'b1;
    tick();
    ram_data_ok = 1'b0;

    // Flush while an instruction read is in flight drops its response.
    if_req = 1'b1; if_addr = 32'h0000_010C; ram_addr_ok = 1'b1;
    tick();
    if_req = 1'b0; ram_addr_ok = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    ram_data_ok = 1'b1; ram_rdata = 32'h0000_CAFE;
    tick();
    check("r34_no_data_ok", {s_if_data_ok, s_if_rdata}, {1'b0, 32'h0});
    ram_data_ok = 1'b0; ram_rdata = '0;
    dm_req = 1'b1; dm_addr = 32'h0000_0400; ram_addr_ok = 1'b1;
    tick();
    check("r34_busy_fell", s_busy, 1'b0);
    check("r34_dm_granted", s_dm_addr_ok, 1'b1);
    dm_req = 1'b0; ram_addr_ok = 1'b0; ram_data_ok = 1'b1; ram_rdata = 32'h0000_0055;
    tick();
    check("r34_dm_rdata", {s_dm_data_ok, s_dm_rdata}, {1'b1, 32'h0000_0055});
    ram_data_ok = 1'b0; ram_rdata = '0;

    // Reset in WAIT, then a stray response.
    if_req = 1'b1; if_addr = 32'h0000_0110; ram_addr_ok = 1'b1;
    tick();
    if_req = 1'b0; ram_addr_ok = 1'b0;
    tick();
    check("r35_in_wait", s_busy, 1'b1);
    rst_n = 1'b0;
    tick();
    check("r35_busy_in_reset", s_busy, 1'b0);
    rst_n = 1'b1; ram_data_ok = 1'b1; ram_rdata = 32'h0000_0BAD;
    tick();
    check("r35_stray", {s_if_data_ok, s_dm_data_ok, s_busy, s_ram_req}, 4'b0000);
    ram_data_ok = 1'b0; ram_rdata = '0;

    // Randomized traffic; requesters hold their fields until accepted.
    for (int i = 0; i < 3000; i++) begin
      if (!if_req && ($urandom_range(0, 2) == 0)) begin
        if_req = 1'b1; if_addr = $urandom;
      end
      if (!dm_req && ($urandom_range(0, 2) == 0)) begin
        dm_req = 1'b1; dm_we = $urandom_range(0, 1); dm_addr = $urandom;
        dm_wdata = $urandom; dm_wstrb = 4'($urandom_range(0, 15));
      end
      flush       = ($urandom_range(0, 5) == 0);
      ram_addr_ok = $urandom_range(0, 1);
      ram_data_ok = ($urandom_range(0, 2) == 0);
      ram_rdata   = $urandom;
      rst_n       = ($urandom_range(0, 99) != 0);
      tick();
      if (e_if_addr_ok || (rst_n == 1'b0)) if_req = 1'b0;
      if (e_dm_addr_ok || (rst_n == 1'b0)) dm_req = 1'b0;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
